// File: rtl/sha3_msg_loader.sv
// Purpose: SHA3 message loader. Packs host words into rate-sized blocks and applies
//          pad10*1 with the DOMAIN byte. Each block goes to the control unit with
//          buff_full / first / last qualifiers.
// Latency: the last word accepted in cycle N gives buff_full in cycle N+1.
//          The extra all-padding block costs one more cycle.
// Backpressure: in_ready is high only while filling a block. A presented block is held
//               until the datapath pulses block_taken.
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   ctrl_valid                    control unit requests a new message (sampled in IDLE only)
//   in_valid/in_data/in_last/in_bytes/in_ready
//                                 host word stream; in_bytes qualifies the final word
//   block, buff_full, first, last presented block and its qualifiers
//   block_taken                   datapath has absorbed the presented block
module sha3_msg_loader #(
  parameter int         RATE_LANES = 17,
  parameter int         LANE_W     = 64,
  parameter logic [7:0] DOMAIN     = 8'h06
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ctrl_valid,
  input  logic                         in_valid,
  input  logic [LANE_W-1:0]            in_data,
  input  logic                         in_last,
  input  logic [3:0]                   in_bytes,
  output logic                         in_ready,
  output logic [RATE_LANES*LANE_W-1:0] block,
  output logic                         buff_full,
  output logic                         first,
  output logic                         last,
  input  logic                         block_taken
);

  localparam int              NB       = LANE_W / 8;
  localparam logic [3:0]      NB4      = 4'(NB);
  localparam int              IDX_W    = (RATE_LANES > 1) ? $clog2(RATE_LANES) : 1;
  localparam int              BLK_W    = RATE_LANES * LANE_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATE_LANES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_FULL,
    S_PAD
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [BLK_W-1:0] block_nxt;
  logic             first_flag, first_nxt;
  logic             last_q, last_nxt;
  logic             pad_pend, pad_nxt;
  logic [3:0]       nb;
  logic [LANE_W-1:0] tail_word;

  // Number of message bytes in the final word, clamped to a full lane.
  always_comb begin
    nb = (in_bytes > NB4) ? NB4 : in_bytes;
  end

  // Final word: keep the valid bytes, put DOMAIN right after them, and zero the rest.
  // When the word is full, DOMAIN goes to the next lane instead.
  always_comb begin
    tail_word = '0;
    for (int k = 0; k < NB; k++) begin
      if (4'(k) < nb) begin
        tail_word[8*k +: 8] = in_data[8*k +: 8];
      end else if (4'(k) == nb) begin
        tail_word[8*k +: 8] = DOMAIN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      block      <= '0;
      first_flag <= 1'b0;
      last_q     <= 1'b0;
      pad_pend   <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      block      <= block_nxt;
      first_flag <= first_nxt;
      last_q     <= last_nxt;
      pad_pend   <= pad_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    block_nxt = block;
    first_nxt = first_flag;
    last_nxt  = last_q;
    pad_nxt   = pad_pend;

    case (state)
      S_IDLE: begin
        if (ctrl_valid) begin
          state_nxt = S_FILL;
          first_nxt = 1'b1;
          block_nxt = '0;
          idx_nxt   = '0;
        end
      end

      S_FILL: begin
        if (in_valid) begin
          if (!in_last) begin
            block_nxt[int'(idx)*LANE_W +: LANE_W] = in_data;
            idx_nxt = idx + IDX_W'(1);
            if (idx == LAST_IDX) begin
              state_nxt = S_FULL;
              last_nxt  = 1'b0;
            end
          end else begin
            block_nxt[int'(idx)*LANE_W +: LANE_W] = tail_word;
            state_nxt = S_FULL;
            if (nb == NB4 && idx == LAST_IDX) begin
              // A full word in the top lane leaves no room for padding.
              // Padding then goes into a separate block.
              pad_nxt  = 1'b1;
              last_nxt = 1'b0;
            end else begin
              if (nb == NB4) begin
                block_nxt[(int'(idx) + 1)*LANE_W +: 8] = DOMAIN;
              end
              // OR so that DOMAIN in the same byte becomes DOMAIN|0x80.
              block_nxt[BLK_W-1 -: 8] = block_nxt[BLK_W-1 -: 8] | 8'h80;
              last_nxt = 1'b1;
            end
          end
        end
      end

      S_FULL: begin
        if (block_taken) begin
          block_nxt = '0;
          idx_nxt   = '0;
          first_nxt = 1'b0;
          last_nxt  = 1'b0;
          if (last_q) begin
            state_nxt = S_IDLE;
          end else if (pad_pend) begin
            state_nxt = S_PAD;
          end else begin
            state_nxt = S_FILL;
          end
        end
      end

      S_PAD: begin
        block_nxt              = '0;
        block_nxt[7:0]         = DOMAIN;
        block_nxt[BLK_W-1 -: 8] = 8'h80;
        state_nxt              = S_FULL;
        last_nxt               = 1'b1;
        pad_nxt                = 1'b0;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign in_ready  = (state == S_FILL);
  assign buff_full = (state == S_FULL);
  assign first     = buff_full && first_flag;
  assign last      = last_q;

endmodule

// File: tb/tb_sha3_msg_loader.sv
module tb_sha3_msg_loader;

  localparam int         RL  = 17;
  localparam int         LW  = 64;
  localparam int         BW  = RL * LW;
  localparam int         RB  = RL * 8;
  localparam logic [7:0] DOM = 8'h06;

  logic          clk;
  logic          rst;
  logic          ctrl_valid;
  logic          in_valid;
  logic [LW-1:0] in_data;
  logic          in_last;
  logic [3:0]    in_bytes;
  logic          in_ready;
  logic [BW-1:0] block;
  logic          buff_full;
  logic          first;
  logic          last;
  logic          block_taken;

  int errors = 0;
  int checks = 0;

  logic [BW-1:0] obs_blk[$];

  sha3_msg_loader #(.RATE_LANES(RL), .LANE_W(LW), .DOMAIN(DOM)) dut (
    .clk(clk), .rst(rst), .ctrl_valid(ctrl_valid), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_bytes(in_bytes), .in_ready(in_ready),
    .block(block), .buff_full(buff_full), .first(first), .last(last),
    .block_taken(block_taken)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic chk_blk(input string nm, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    bit shown;
    shown = 0;
    checks++;
    if (got !== exp) begin
      errors++;
      for (int l = 0; l < RL; l++) begin
        if (!shown && got[l*LW +: LW] !== exp[l*LW +: LW]) begin
          $display("FAIL %s: lane %0d got %h expected %h", nm, l, got[l*LW +: LW], exp[l*LW +: LW]);
          shown = 1;
        end
      end
    end
  endtask

  // Sends one message and checks every block against a byte-level pad10*1 model.
  // Called and returns just after a falling edge, with the DUT idle.
  task automatic run_message(input string nm, input int nwords, input int lb,
                             input logic [63:0] w0, input bit rnd_data, input bit gaps);
    logic [63:0]   words[$];
    logic [7:0]    msg[$];
    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] blk;
    int wi, bi, hold, nb;
    bit seen, last_sent, done;

    for (int i = 0; i < nwords; i++) begin
      if (rnd_data) words.push_back({$urandom, $urandom});
      else if (i == 0) words.push_back(w0);
      else words.push_back({8{8'(i)}});
    end
    // Reference: message bytes, then DOMAIN, zero-fill to a rate multiple, 0x80 into the final byte.
    for (int i = 0; i < nwords; i++) begin
      nb = (i == nwords - 1) ? ((lb > 8) ? 8 : lb) : 8;
      for (int j = 0; j < nb; j++) msg.push_back(words[i][8*j +: 8]);
    end
    msg.push_back(DOM);
    while (msg.size() % RB != 0) msg.push_back(8'h00);
    msg[msg.size()-1] = msg[msg.size()-1] | 8'h80;
    for (int k = 0; k < msg.size() / RB; k++) begin
      blk = '0;
      for (int j = 0; j < RB; j++) blk[8*j +: 8] = msg[k*RB + j];
      exp_q.push_back(blk);
    end

    obs_blk.delete();
    wi = 0; bi = 0; hold = 0; seen = 0; last_sent = 0; done = 0;
    in_valid = 1'b0;
    ctrl_valid = 1'b1;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      @(negedge clk);
      if (last_sent) begin
        chk({nm, "_latency"}, buff_full, 1'b1);
        last_sent = 0;
      end
      if (buff_full) begin
        chk({nm, "_ready_in_full"}, in_ready, 1'b0);
        if (!seen) begin
          if (bi < exp_q.size()) begin
            chk_blk({nm, "_block"}, block, exp_q[bi]);
            chk({nm, "_first"}, first, (bi == 0));
            chk({nm, "_last"}, last, (bi == exp_q.size() - 1));
          end else begin
            chk({nm, "_extra_block"}, bi, exp_q.size() - 1);
          end
          obs_blk.push_back(block);
          seen = 1;
          hold = gaps ? $urandom_range(0, 2) : 0;
        end
        if (hold == 0) begin
          block_taken = 1'b1;
          seen = 0;
          bi++;
          if (bi >= exp_q.size()) done = 1;
        end else begin
          hold--;
          block_taken = 1'b0;
        end
      end else begin
        block_taken = gaps && ($urandom_range(0, 3) == 0);
      end
      ctrl_valid = gaps && ($urandom_range(0, 2) == 0);
      if (done) ctrl_valid = 1'b0;
      if (wi < nwords && (!gaps || $urandom_range(0, 2) != 0)) begin
        in_valid = 1'b1;
        in_data  = words[wi];
        in_last  = (wi == nwords - 1);
        in_bytes = in_last ? 4'(lb) : 4'($urandom_range(0, 15));
        if (in_ready) begin
          if (in_last) last_sent = 1;
          wi++;
        end
      end else begin
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
        in_last  = 1'($urandom_range(0, 1));
        in_bytes = 4'($urandom_range(0, 15));
      end
    end
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL %s_timeout: blocks seen %0d required %0d", nm, bi, exp_q.size());
    end
    @(negedge clk);
    block_taken = 1'b0;
    in_valid    = 1'b0;
    ctrl_valid  = 1'b0;
    chk({nm, "_words_used"}, wi, nwords);
    chk({nm, "_full_drop"}, buff_full, 1'b0);
    chk({nm, "_last_drop"}, last, 1'b0);
    chk({nm, "_idle_ready"}, in_ready, 1'b0);
  endtask

  typedef struct {
    string       name;
    int          nwords;
    int          lb;
    logic [63:0] w0;
    bit          gaps;
    int          nblk;
    logic [63:0] lane0_first;
    logic [63:0] lane0_final;
    logic [63:0] lane16_final;
  } vec_t;

  vec_t          vecs[7];
  logic [BW-1:0] tmp;

  initial begin
    vecs[0] = '{"empty",    1,  0, 64'hDEAD_BEEF_CAFE_F00D, 0, 1,
                64'h06, 64'h06, 64'h8000_0000_0000_0000};
    vecs[1] = '{"abc",      1,  3, 64'h0000_0000_0063_6261, 0, 1,
                64'h0000_0000_0663_6261, 64'h0000_0000_0663_6261, 64'h8000_0000_0000_0000};
    vecs[2] = '{"tail16b7", 17, 7, 64'h0123_4567_89AB_CDEF, 0, 1,
                64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 64'h8610_1010_1010_1010};
    vecs[3] = '{"exact17",  17, 8, 64'h0123_4567_89AB_CDEF, 0, 2,
                64'h0123_4567_89AB_CDEF, 64'h06, 64'h8000_0000_0000_0000};
    vecs[4] = '{"dom16",    16, 8, 64'h0123_4567_89AB_CDEF, 0, 1,
                64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 64'h8000_0000_0000_0006};
    vecs[5] = '{"clamp15",  1, 15, 64'h1122_3344_5566_7788, 0, 1,
                64'h1122_3344_5566_7788, 64'h1122_3344_5566_7788, 64'h8000_0000_0000_0000};
    vecs[6] = '{"gaps40",   40, 8, 64'h0123_4567_89AB_CDEF, 1, 3,
                64'h0123_4567_89AB_CDEF, 64'h2222_2222_2222_2222, 64'h8000_0000_0000_0000};

    rst = 1'b1; ctrl_valid = 1'b0; in_valid = 1'b0; in_data = '0;
    in_last = 1'b0; in_bytes = '0; block_taken = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_buff_full", buff_full, 1'b0);
    chk("rst_first", first, 1'b0);
    chk("rst_last", last, 1'b0);
    chk_blk("rst_block", block, '0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      run_message(vecs[v].name, vecs[v].nwords, vecs[v].lb, vecs[v].w0, 1'b0, vecs[v].gaps);
      chk({vecs[v].name, "_nblk"}, obs_blk.size(), vecs[v].nblk);
      if (obs_blk.size() > 0) begin
        tmp = obs_blk[0];
        chk({vecs[v].name, "_lane0_first"}, tmp[63:0], vecs[v].lane0_first);
        tmp = obs_blk[obs_blk.size()-1];
        chk({vecs[v].name, "_lane0_final"}, tmp[63:0], vecs[v].lane0_final);
        chk({vecs[v].name, "_lane16_final"}, tmp[16*LW +: LW], vecs[v].lane16_final);
      end
    end

    // Reset partway through a block, after five lanes are loaded.
    ctrl_valid = 1'b1;
    @(negedge clk);
    ctrl_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_last = 1'b0; in_data = {$urandom, $urandom};
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("midrst_ready_before", in_ready, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", in_ready, 1'b0);
    chk("midrst_buff_full", buff_full, 1'b0);
    chk("midrst_first", first, 1'b0);
    chk("midrst_last", last, 1'b0);
    chk_blk("midrst_block", block, '0);
    in_valid = 1'b1; in_last = 1'b1; in_bytes = 4'd3; in_data = {$urandom, $urandom};
    @(negedge clk);
    chk("midrst_idle_ignores_word", in_ready, 1'b0);
    chk("midrst_idle_no_block", buff_full, 1'b0);
    in_valid = 1'b0;
    run_message("after_rst", 1, 3, 64'h0000_0000_0063_6261, 1'b0, 1'b0);
    if (obs_blk.size() > 0) begin
      tmp = obs_blk[0];
      chk("after_rst_lane0", tmp[63:0], 64'h0000_0000_0663_6261);
    end

    for (int r = 0; r < 25; r++) begin
      run_message($sformatf("rand%0d", r), $urandom_range(1, 40), $urandom_range(0, 15),
                  64'h0, 1'b1, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
